// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame receiver.
package uart_frame_pkg;

   localparam int unsigned NUM_CH_DEF    = 32;
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [1:0] {
      BS_IDLE  = 2'd0,
      BS_START = 2'd1,
      BS_DATA  = 2'd2,
      BS_STOP  = 2'd3
   } byte_state_t;

   typedef enum logic [1:0] {
      FS_HUNT    = 2'd0,
      FS_PAYLOAD = 2'd1,
      FS_CHECK   = 2'd2,
      FS_COMMIT  = 2'd3
   } frame_state_t;

endpackage

// File: rtl/uart_frame_rx_byte.sv
// 8N1 byte receiver: input synchronizer, baud counter and byte FSM.
module uart_byte_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   byte_state_t      state_q, state_d;
   logic [1:0]       sync_q;
   logic             rx_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             rx_s;

   assign rx_s = sync_q[1];

   // Synchronizer and edge history reset to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], rx_pin};
         rx_prev_q <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BS_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         BS_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s) state_d = BS_START;
         end
         BS_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? BS_IDLE : BS_DATA;
            end
         end
         BS_DATA: begin
            // LSB arrives first, so shift in from the top.
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shreg_d = {rx_s, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = BS_STOP;
            end
         end
         BS_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = BS_IDLE;
               valid_d = rx_s;
               err_d   = !rx_s;
            end
         end
         default: state_d = BS_IDLE;
      endcase
   end

   assign byte_data  = shreg_q;
   assign byte_valid = valid_q;
   assign byte_err   = err_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler: sync hunt, payload shadow, checksum check and handshaked output buffer.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned NUM_CH    = NUM_CH_DEF,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] out_channel_data [NUM_CH],
   output logic       data_ready,
   input  logic       data_acknowledge,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_err;

   frame_state_t     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [7:0]       shadow_q [NUM_CH];
   logic [7:0]       shadow_d [NUM_CH];
   logic [7:0]       out_q [NUM_CH];
   logic [7:0]       out_d [NUM_CH];
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             buf_free_c;

   uart_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_pin     (rx_pin),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_err   (byte_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FS_HUNT;
         idx_q    <= '0;
         sum_q    <= '0;
         shadow_q <= '{default: '0};
         out_q    <= '{default: '0};
         ready_q  <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sum_q    <= sum_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         ready_q  <= ready_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   // An ack in the same cycle frees the buffer for an incoming commit.
   assign buf_free_c = !ready_q || data_acknowledge;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sum_d    = sum_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      ready_d  = ready_q && !data_acknowledge;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;
      case (state_q)
         FS_HUNT: begin
            if (byte_valid && (byte_data == SYNC_BYTE)) begin
               state_d = FS_PAYLOAD;
               idx_d   = '0;
               sum_d   = '0;
            end
         end
         FS_PAYLOAD: begin
            if (byte_valid) begin
               shadow_d[idx_q] = byte_data;
               sum_d           = sum_q + byte_data;
               idx_d           = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) state_d = FS_CHECK;
            end
         end
         FS_CHECK: begin
            if (byte_valid) begin
               state_d = FS_HUNT;
               if (byte_data != sum_q)  ferr_d  = 1'b1;
               else if (buf_free_c)     state_d = FS_COMMIT;
               else                     ovr_d   = 1'b1;
            end
         end
         FS_COMMIT: begin
            out_d   = shadow_q;
            ready_d = 1'b1;
            state_d = FS_HUNT;
         end
         default: state_d = FS_HUNT;
      endcase
      // A framing error abandons any partial frame; a pending commit still lands.
      if (byte_err) begin
         ferr_d  = 1'b1;
         state_d = FS_HUNT;
      end
   end

   assign out_channel_data = out_q;
   assign data_ready       = ready_q;
   assign frame_err        = ferr_q;
   assign overrun          = ovr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at 10 clocks per bit.
module tb_uart_frame_rx;
   import uart_frame_pkg::*;

   localparam int unsigned N = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_pin;
   logic [7:0] out_data [N];
   logic       data_ready;
   logic       data_ack;
   logic       frame_err;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_start = 0;
   int rise_cyc = -1;
   logic dr_prev = 1'b0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int bv_cnt = 0;
   int f0, o0, b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      dr_prev <= data_ready;
      if (data_ready && !dr_prev) rise_cyc <= cyc;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (dut.u_byte.byte_valid) bv_cnt <= bv_cnt + 1;
   end

   uart_frame_rx #(
      .CLK_FREQ  (1_000_000),
      .BAUD      (100_000),
      .NUM_CH    (N),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rx_pin           (rx_pin),
      .out_channel_data (out_data),
      .data_ready       (data_ready),
      .data_acknowledge (data_ack),
      .frame_err        (frame_err),
      .overrun          (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      last_start = cyc;
      rx_pin = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (10) @(negedge clk);
      end
      rx_pin = stop_bit;
      repeat (10) @(negedge clk);
      rx_pin = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] first, input logic [7:0] step,
                             input logic [7:0] cks, input int bad_idx);
      logic [7:0] v;
      v = first;
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < N; i++) begin
         send_byte(v, i != bad_idx);
         if (i == bad_idx) repeat (20) @(negedge clk);
         v = v + step;
      end
      send_byte(cks, 1'b1);
   endtask

   task automatic chk_buf(input string tag, input logic [7:0] first, input logic [7:0] step);
      logic [7:0] v;
      v = first;
      for (int i = 0; i < N; i++) begin
         chk(tag, 32'(out_data[i]), 32'(v));
         v = v + step;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_pin   = 1'b1;
      data_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_ready", 32'(data_ready), 32'd0);
      chk("reset_ferr", 32'(frame_err), 32'd0);
      chk("reset_ovr", 32'(overrun), 32'd0);
      chk_buf("reset_buf", 8'h00, 8'h00);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // 1: good frame 00..1F, checksum F0
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 8'h01, 8'hF0, -1);
      @(negedge clk);
      chk("t1_ready", 32'(data_ready), 32'd1);
      chk("t1_latency", 32'(rise_cyc), 32'(last_start + 100));
      chk_buf("t1_buf", 8'h00, 8'h01);
      chk("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("t1_ovr", 32'(ovr_cnt - o0), 32'd0);
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      chk("t1_ack_clear", 32'(data_ready), 32'd0);

      // Reset clears the held buffer
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_buf("rst_buf", 8'h00, 8'h00);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // 2: bad checksum
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 8'h01, 8'hF1, -1);
      repeat (5) @(negedge clk);
      chk("t2_ferr", 32'(ferr_cnt - f0), 32'd1);
      chk("t2_ready", 32'(data_ready), 32'd0);
      chk("t2_buf0", 32'(out_data[0]), 32'd0);
      chk("t2_buf31", 32'(out_data[31]), 32'd0);

      // 3: two good frames, no ack
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h11, 8'h00, 8'h20, -1);
      send_frame(8'h11, 8'h00, 8'h20, -1);
      repeat (5) @(negedge clk);
      chk("t3_ready", 32'(data_ready), 32'd1);
      chk_buf("t3_buf", 8'h11, 8'h00);
      chk("t3_ovr", 32'(ovr_cnt - o0), 32'd1);
      chk("t3_ferr", 32'(ferr_cnt - f0), 32'd0);
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      chk("t3_ack_clear", 32'(data_ready), 32'd0);

      // 4: stop error on payload byte 5, then a good frame 21..40
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 8'h01, 8'hF0, 5);
      repeat (5) @(negedge clk);
      chk("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
      chk("t4_ready_after_err", 32'(data_ready), 32'd0);
      send_frame(8'h21, 8'h01, 8'h10, -1);
      @(negedge clk);
      chk("t4_ready", 32'(data_ready), 32'd1);
      chk("t4_latency", 32'(rise_cyc), 32'(last_start + 100));
      chk_buf("t4_buf", 8'h21, 8'h01);
      chk("t4_ferr_total", 32'(ferr_cnt - f0), 32'd1);
      chk("t4_ovr", 32'(ovr_cnt - o0), 32'd0);

      // 5: 3-cycle glitch on idle line
      f0 = ferr_cnt; o0 = ovr_cnt; b0 = bv_cnt;
      rx_pin = 1'b0;
      repeat (3) @(negedge clk);
      rx_pin = 1'b1;
      repeat (30) @(negedge clk);
      chk("t5_bytes", 32'(bv_cnt - b0), 32'd0);
      chk("t5_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("t5_ovr", 32'(ovr_cnt - o0), 32'd0);
      chk("t5_idle", 32'(dut.u_byte.state_q), 32'(BS_IDLE));
      chk("t5_held", 32'(data_ready), 32'd1);

      // 6: reset during payload byte 20 while the previous frame is held
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1);
      rx_pin = 1'b0;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(data_ready), 32'd0);
      chk("t6_rst_ferr", 32'(frame_err), 32'd0);
      chk("t6_rst_ovr", 32'(overrun), 32'd0);
      chk_buf("t6_rst_buf", 8'h00, 8'h00);
      @(negedge clk);
      rx_pin = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h00, 8'h01, 8'hF0, -1);
      @(negedge clk);
      chk("t6_ready", 32'(data_ready), 32'd1);
      chk("t6_latency", 32'(rise_cyc), 32'(last_start + 100));
      chk_buf("t6_buf", 8'h00, 8'h01);
      chk("t6_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("t6_ovr", 32'(ovr_cnt - o0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
